// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the ROM read port and the decoder-facing instruction
// handshake, bundled so fetch_unit has a single bus port.
//   master : fetch_unit side (drives ROM address/enable and the instruction)
//   slave  : ROM + decoder side (drives ROM data, ready and jump requests)
// Signals:
//   rom_addr, rom_read_en, rom_data      ROM read port
//   instr_valid, instr_ready             instruction handshake
//   opcode, imm, has_imm, instr_pc       instruction payload
//   jump_en, jump_addr                   jump request from the decoder
//   halted                               HLT retired, fetch stopped
interface fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic [DATA_W-1:0] rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] opcode;
  logic [DATA_W-1:0] imm;
  logic              has_imm;
  logic [ADDR_W-1:0] instr_pc;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halted;

  modport master (
    output rom_addr, rom_read_en, instr_valid, opcode, imm, has_imm,
           instr_pc, halted,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  rom_addr, rom_read_en, instr_valid, opcode, imm, has_imm,
           instr_pc, halted,
    output rom_data, instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, reads the combinational program
// ROM, assembles one- or two-byte instructions and offers them to the
// decoder over a valid/ready handshake. Applies decoder jump targets and
// stops fetching for good (until reset) once HLT is accepted.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (ROM port + decoder handshake)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH_OP  | read opcode byte at pc
// FETCH_IMM | read imm8 byte at pc (two-byte opcodes only)
// HOLD      | instruction presented, waiting for instr_ready
// HALT      | HLT accepted; no reads, no valid, exit only via reset
module fetch_unit #(
  parameter int          ADDR_W    = 4,
  parameter int          DATA_W    = 8,
  parameter logic [3:0]  IMM_OPC_A = 4'hB,
  parameter logic [3:0]  IMM_OPC_B = 4'hC,
  parameter logic [7:0]  HLT_OPC   = 8'hF0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2,
    HALT      = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] imm_q;
  logic              has_imm_q;
  logic              instr_valid_q;
  logic              halted_q;
  logic              two_byte;

  assign two_byte = (bus.rom_data[DATA_W-1 -: 4] == IMM_OPC_A) ||
                    (bus.rom_data[DATA_W-1 -: 4] == IMM_OPC_B);

  assign bus.rom_addr    = pc_q;
  // Gated by rst_n so the ROM is idle for the whole reset pulse.
  assign bus.rom_read_en = rst_n & ((state_q == FETCH_OP) || (state_q == FETCH_IMM));
  assign bus.instr_valid = instr_valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.imm         = imm_q;
  assign bus.has_imm     = has_imm_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_OP;
      pc_q          <= '0;
      instr_pc_q    <= '0;
      opcode_q      <= '0;
      imm_q         <= '0;
      has_imm_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: begin
          opcode_q   <= bus.rom_data;
          instr_pc_q <= pc_q;
          pc_q       <= pc_q + 1'b1;
          if (two_byte) begin
            state_q <= FETCH_IMM;
          end else begin
            imm_q         <= '0;
            has_imm_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        FETCH_IMM: begin
          // pc wraps naturally, so an opcode at the top address takes its imm from 0.
          imm_q         <= bus.rom_data;
          has_imm_q     <= 1'b1;
          pc_q          <= pc_q + 1'b1;
          instr_valid_q <= 1'b1;
          state_q       <= HOLD;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            // HLT takes priority over a simultaneous jump; pc is left alone.
            if (opcode_q == HLT_OPC) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              if (bus.jump_en) pc_q <= bus.jump_addr;
              state_q <= FETCH_OP;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] imm;
    logic       has;
    logic [3:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rom [16];
  logic force_jump = 1'b0;
  logic auto_jump = 1'b0;
  logic [15:0] read_mask = '0;
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rom_data  = bus.rom_read_en ? rom[bus.rom_addr] : 8'h00;
  // Decoder model: JMP (opcode 0xC_) jumps to its truncated immediate.
  assign bus.jump_en   = force_jump |
                         (auto_jump & bus.instr_valid & (bus.opcode[7:4] == 4'hC));
  assign bus.jump_addr = bus.imm[3:0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compare each accepted instruction with the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.rom_read_en) read_mask[bus.rom_addr] <= 1'b1;
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      hs_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got op=%h pc=%0d, want no instruction",
                 bus.opcode, bus.instr_pc);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.opcode, bus.imm, bus.has_imm, bus.instr_pc} !== mon_e) begin
          errors++;
          $display("FAIL sb_instr: got op=%h imm=%h has=%b pc=%0d want op=%h imm=%h has=%b pc=%0d",
                   bus.opcode, bus.imm, bus.has_imm, bus.instr_pc,
                   mon_e.op, mon_e.imm, mon_e.has, mon_e.pc);
        end
      end
    end
  end

  task automatic push(input logic [7:0] op, input logic [7:0] imm, input logic has,
                      input logic [3:0] pc);
    sb_q.push_back({op, imm, has, pc});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", {4'h0, bus.instr_valid, bus.halted, bus.rom_read_en, bus.has_imm,
                      bus.rom_addr, bus.instr_pc, bus.opcode, bus.imm}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid_pc(input logic [3:0] pc, input int budget);
    int n = 0;
    while (!(bus.instr_valid && bus.instr_pc == pc) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid", {27'h0, bus.instr_valid, bus.instr_pc}, {27'h0, 1'b1, pc});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.instr_ready = 1'b0;
    chk("drain", sb_q.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    bus.instr_ready = 1'b0;

    // Program A: one/two-byte mix, a JMP over 7..9, then HLT.
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h15; rom[1] = 8'h20; rom[2] = 8'hB0; rom[3] = 8'h0A;
    rom[4] = 8'h21; rom[5] = 8'hC0; rom[6] = 8'h0A;
    rom[7] = 8'hEE; rom[8] = 8'hEE; rom[9] = 8'hEE;
    rom[10] = 8'h42; rom[11] = 8'hF0;
    push(8'h15, 8'h00, 1'b0, 4'd0);
    push(8'h20, 8'h00, 1'b0, 4'd1);
    push(8'hB0, 8'h0A, 1'b1, 4'd2);
    push(8'h21, 8'h00, 1'b0, 4'd4);
    push(8'hC0, 8'h0A, 1'b1, 4'd5);
    push(8'h42, 8'h00, 1'b0, 4'd10);
    push(8'hF0, 8'h00, 1'b0, 4'd11);
    auto_jump = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    read_mask = '0;
    @(posedge clk);
    #1;
    chk("first_valid", {bus.instr_valid, bus.opcode, bus.imm, bus.has_imm, bus.instr_pc, bus.rom_addr},
        {1'b1, 8'h15, 8'h00, 1'b0, 4'h0, 4'h1});
    wait_valid_pc(4'hB, 40);
    force_jump = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_enter", {bus.halted, bus.instr_valid, bus.rom_read_en, bus.rom_addr},
        {1'b1, 1'b0, 1'b0, 4'hC});
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("halt_hold", {bus.halted, bus.instr_valid, bus.rom_read_en, bus.rom_addr},
          {1'b1, 1'b0, 1'b0, 4'hC});
    end
    chk("read_mask", read_mask, 16'h0C7F);
    chk("sb_empty_a", sb_q.size(), 0);
    force_jump = 1'b0;

    // Stall: two-byte instruction held for 5 cycles with ready low.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'hB0; rom[1] = 8'h5A; rom[2] = 8'h77;
    push(8'hB0, 8'h5A, 1'b1, 4'd0);
    do_reset();
    wait_valid_pc(4'h0, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall", {bus.instr_valid, bus.opcode, bus.imm, bus.has_imm, bus.instr_pc,
                    bus.rom_read_en, bus.rom_addr},
          {1'b1, 8'hB0, 8'h5A, 1'b1, 4'h0, 1'b0, 4'h2});
    end
    hs0 = hs_count;
    bus.instr_ready = 1'b1;
    @(posedge clk);
    #1 bus.instr_ready = 1'b0;
    chk("valid_drop", {bus.instr_valid, bus.rom_read_en, bus.rom_addr}, {1'b0, 1'b1, 4'h2});
    repeat (4) @(posedge clk);
    #1;
    chk("one_hs", hs_count - hs0, 1);
    chk("next_stall", {bus.instr_valid, bus.opcode, bus.instr_pc}, {1'b1, 8'h77, 4'h2});
    chk("sb_empty_b", sb_q.size(), 0);

    // Wrap: two-byte opcode at 15 takes its imm from address 0.
    rom[0] = 8'h33;
    for (int i = 1; i < 15; i++) rom[i] = 8'h10 + 8'(i);
    rom[15] = 8'hB0;
    push(8'h33, 8'h00, 1'b0, 4'd0);
    for (int i = 1; i < 15; i++) push(8'h10 + 8'(i), 8'h00, 1'b0, 4'(i));
    push(8'hB0, 8'h33, 1'b1, 4'd15);
    push(8'h11, 8'h00, 1'b0, 4'd1);
    do_reset();
    bus.instr_ready = 1'b1;
    wait_valid_pc(4'hF, 60);
    chk("wrap", {bus.opcode, bus.imm, bus.has_imm, bus.rom_addr}, {8'hB0, 8'h33, 1'b1, 4'h1});
    wait_drain(10);

    // Asynchronous reset in the middle of FETCH_IMM.
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'hB0; rom[1] = 8'h44;
    do_reset();
    bus.instr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_imm", {bus.instr_valid, bus.rom_read_en, bus.rom_addr, bus.opcode},
        {1'b0, 1'b1, 4'h1, 8'hB0});
    rst_n = 1'b0;
    #1;
    chk("async_clr", {bus.instr_valid, bus.rom_read_en, bus.rom_addr, bus.instr_pc,
                      bus.opcode, bus.has_imm}, 0);
    push(8'hB0, 8'h44, 1'b1, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
